vx_wctl_accum_unit: RTL and testbench

VX_WCTL_ACCUM_UNIT -- requirements
Module: VX_wctl_accum_unit

---
 rtl/vx_wctl_accum_unit.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_vx_wctl_accum_unit.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_wctl_accum_unit.sv
// -----------------------------------------------------------------------------
// vx_wctl_accum_unit
//
// Warp-control accumulator. Warp-control instructions arrive as a sequence of
// NUM_LANES-wide packets (sop .. eop) covering a full NUM_THREADS-wide warp.
// Per warp, the unit assembles then/else thread masks from the lane predicates
// and, on the eop packet, emits one registered warp-control record (TMC, PRED,
// SPLIT, JOIN, BAR, WSPAWN). Every accepted packet also pushes {wid, eop} into
// a small response FIFO.
//
// Ports
//   clk, reset          clock, asynchronous active-low reset
//   in_valid/in_ready   packet handshake (in_ready = FIFO not full || rsp_ready)
//   in_wid, in_op       warp id, op (0 TMC 1 PRED 2 SPLIT 3 JOIN 4 BAR 5 WSPAWN)
//   in_neg              predicate invert
//   in_tmask, in_pid    lane mask, packet index inside the warp
//   in_sop, in_eop      packet framing
//   in_pc               pc of the instruction
//   in_rs1, in_rs2      operands, lane i at [i*XLEN +: XLEN]
//   ctl_*               warp-control record, valid for one cycle after eop
//   rsp_valid/rsp_ready response FIFO output handshake
//   rsp_wid, rsp_eop    response FIFO head
//   err_seq             sticky sop/eop sequencing error
//
// Configuration macro
//   VX_WCTL_GBAR_EN     when defined, BAR passes rs1[XLEN-1] (global barrier
//                       flag) through ctl_arg; otherwise that bit is zero.
// -----------------------------------------------------------------------------
module vx_wctl_accum_unit #(
    parameter int NUM_LANES   = 4,
    parameter int NUM_THREADS = 8,
    parameter int NUM_WARPS   = 4,
    parameter int XLEN        = 32,
    parameter int PC_BITS     = 30,
    parameter int RSP_DEPTH   = 2,
    localparam int WID_W      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int PID_W      = (NUM_THREADS / NUM_LANES > 1) ? $clog2(NUM_THREADS / NUM_LANES) : 1
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WID_W-1:0]          in_wid,
    input  logic [2:0]                in_op,
    input  logic                      in_neg,
    input  logic [NUM_LANES-1:0]      in_tmask,
    input  logic [PID_W-1:0]          in_pid,
    input  logic                      in_sop,
    input  logic                      in_eop,
    input  logic [PC_BITS-1:0]        in_pc,
    input  logic [NUM_LANES*XLEN-1:0] in_rs1,
    input  logic [NUM_LANES*XLEN-1:0] in_rs2,

    output logic                      ctl_valid,
    output logic [WID_W-1:0]          ctl_wid,
    output logic [2:0]                ctl_op,
    output logic [NUM_THREADS-1:0]    ctl_tmask,
    output logic [NUM_THREADS-1:0]    ctl_else_tmask,
    output logic                      ctl_is_dvg,
    output logic [PC_BITS-1:0]        ctl_next_pc,
    output logic [XLEN-1:0]           ctl_arg,

    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [WID_W-1:0]          rsp_wid,
    output logic                      rsp_eop,
    output logic                      err_seq
);

    localparam int NT     = NUM_THREADS;
    localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int PTR_W  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W  = $clog2(RSP_DEPTH + 1);

    localparam logic [2:0] OP_TMC    = 3'd0;
    localparam logic [2:0] OP_PRED   = 3'd1;
    localparam logic [2:0] OP_SPLIT  = 3'd2;
    localparam logic [2:0] OP_JOIN   = 3'd3;
    localparam logic [2:0] OP_BAR    = 3'd4;
    localparam logic [2:0] OP_WSPAWN = 3'd5;

    typedef enum logic {
        W_IDLE  = 1'b0,
        W_ACCUM = 1'b1
    } wstate_e;

    function automatic int unsigned popcnt(input logic [NT-1:0] v);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < NT; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

    // ------------------------------------------------------------------
    // Handshake / FIFO status
    // ------------------------------------------------------------------
    logic [WID_W:0]     fifo_mem [RSP_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               full, fire, pop;

    assign full      = (count == CNT_W'(RSP_DEPTH));
    assign rsp_valid = (count != '0);
    // A full FIFO still accepts when the head drains in the same cycle.
    assign in_ready  = !full || rsp_ready;
    assign fire      = in_valid && in_ready;
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_wid   = fifo_mem[rd_ptr][WID_W:1];
    assign rsp_eop   = fifo_mem[rd_ptr][0];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < RSP_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (fire) begin
                fifo_mem[wr_ptr] <= {in_wid, in_eop};
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (fire && !pop) begin
                count <= count + 1'b1;
            end else if (!fire && pop) begin
                count <= count - 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-warp sequencing state and mask accumulation
    // ------------------------------------------------------------------
    wstate_e           state_q [NUM_WARPS];
    logic [NT-1:0]     then_q  [NUM_WARPS];
    logic [NT-1:0]     else_q  [NUM_WARPS];

    wstate_e           cur_state, state_n;
    logic              seq_err, eff_sop;
    logic [NUM_LANES-1:0] taken, then_slice, else_slice;
    logic [NT-1:0]     then_new, else_new;

    always_comb begin
        cur_state = state_q[in_wid];
        seq_err   = in_sop ? (cur_state == W_ACCUM) : (cur_state == W_IDLE);
        // A mis-sequenced packet restarts the warp as a fresh sop.
        eff_sop   = in_sop || seq_err;
        state_n   = in_eop ? W_IDLE : W_ACCUM;

        taken = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            taken[i] = in_rs1[i*XLEN] ^ in_neg;
        end
        then_slice = taken & in_tmask;
        else_slice = ~taken & in_tmask;

        then_new = (eff_sop ? '0 : then_q[in_wid]) | (NT'(then_slice) << (in_pid * NUM_LANES));
        else_new = (eff_sop ? '0 : else_q[in_wid]) | (NT'(else_slice) << (in_pid * NUM_LANES));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned w = 0; w < NUM_WARPS; w++) begin
                state_q[w] <= W_IDLE;
                then_q[w]  <= '0;
                else_q[w]  <= '0;
            end
            err_seq <= 1'b0;
        end else if (fire) begin
            state_q[in_wid] <= state_n;
            then_q[in_wid]  <= then_new;
            else_q[in_wid]  <= else_new;
            if (seq_err) begin
                err_seq <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Last-lane operand selection and control record decode
    // ------------------------------------------------------------------
    logic [LANE_W-1:0] last_lane;
    logic [XLEN-1:0]   rs1_last, rs2_last;
    logic              unused_rs2;

    always_comb begin
        last_lane = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (in_tmask[i]) begin
                last_lane = LANE_W'(i);
            end
        end
        rs1_last = in_rs1[last_lane*XLEN +: XLEN];
        rs2_last = in_rs2[last_lane*XLEN +: XLEN];
    end

    assign unused_rs2 = ^rs2_last;

    logic [NT-1:0]      n_tmask, n_else;
    logic               n_dvg;
    logic [PC_BITS-1:0] n_pc;
    logic [XLEN-1:0]    n_arg;

    always_comb begin
        n_tmask = '0;
        n_else  = '0;
        n_dvg   = 1'b0;
        n_pc    = '0;
        n_arg   = '0;
        case (in_op)
            OP_TMC: begin
                n_tmask = NT'(rs1_last);
            end
            OP_PRED: begin
                n_tmask = (then_new != '0) ? then_new : NT'(rs2_last);
            end
            OP_SPLIT: begin
                n_dvg = (then_new != '0) && (else_new != '0);
                if (popcnt(then_new) >= popcnt(else_new)) begin
                    n_tmask = then_new;
                    n_else  = else_new;
                end else begin
                    n_tmask = else_new;
                    n_else  = then_new;
                end
                n_pc = in_pc + PC_BITS'(2);
            end
            OP_JOIN: begin
                n_arg = rs1_last;
            end
            OP_BAR: begin
`ifdef VX_WCTL_GBAR_EN
                n_arg = rs1_last;
`else
                n_arg = {1'b0, rs1_last[XLEN-2:0]};
`endif
            end
            OP_WSPAWN: begin
                for (int unsigned w = 0; w < NUM_WARPS; w++) begin
                    n_tmask[w] = (XLEN'(w) < rs1_last) && (WID_W'(w) != in_wid);
                end
                n_pc = rs2_last[PC_BITS:1];
            end
            default: ;
        endcase
    end

    // Record registers are zero whenever no record is being presented.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctl_valid      <= 1'b0;
            ctl_wid        <= '0;
            ctl_op         <= '0;
            ctl_tmask      <= '0;
            ctl_else_tmask <= '0;
            ctl_is_dvg     <= 1'b0;
            ctl_next_pc    <= '0;
            ctl_arg        <= '0;
        end else if (fire && in_eop) begin
            ctl_valid      <= 1'b1;
            ctl_wid        <= in_wid;
            ctl_op         <= in_op;
            ctl_tmask      <= n_tmask;
            ctl_else_tmask <= n_else;
            ctl_is_dvg     <= n_dvg;
            ctl_next_pc    <= n_pc;
            ctl_arg        <= n_arg;
        end else begin
            ctl_valid      <= 1'b0;
            ctl_wid        <= '0;
            ctl_op         <= '0;
            ctl_tmask      <= '0;
            ctl_else_tmask <= '0;
            ctl_is_dvg     <= 1'b0;
            ctl_next_pc    <= '0;
            ctl_arg        <= '0;
        end
    end

endmodule

// File: tb/tb_vx_wctl_accum_unit.sv
// -----------------------------------------------------------------------------
// tb_vx_wctl_accum_unit
//
// Directed scenarios plus a randomized packet stream for vx_wctl_accum_unit
// at its default geometry (4 lanes, 8 threads, 4 warps, XLEN 32, PC 30 bits,
// 2-entry response FIFO). Expected records come from a warp-level model that
// keeps each warp's then/else thread sets and evaluates each op's rule.
// -----------------------------------------------------------------------------
module tb_vx_wctl_accum_unit;

    localparam int NL = 4, NT = 8, NW = 4, XL = 32, PCB = 30, DEPTH = 2;
`ifdef VX_WCTL_GBAR_EN
    localparam bit GBAR = 1'b1;
`else
    localparam bit GBAR = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid, in_ready;
    logic [1:0]     in_wid;
    logic [2:0]     in_op;
    logic           in_neg;
    logic [NL-1:0]  in_tmask;
    logic [0:0]     in_pid;
    logic           in_sop, in_eop;
    logic [PCB-1:0] in_pc;
    logic [NL*XL-1:0] in_rs1, in_rs2;
    logic           ctl_valid;
    logic [1:0]     ctl_wid;
    logic [2:0]     ctl_op;
    logic [NT-1:0]  ctl_tmask, ctl_else_tmask;
    logic           ctl_is_dvg;
    logic [PCB-1:0] ctl_next_pc;
    logic [XL-1:0]  ctl_arg;
    logic           rsp_valid, rsp_ready;
    logic [1:0]     rsp_wid;
    logic           rsp_eop, err_seq;

    always #5 clk = ~clk;

    vx_wctl_accum_unit #(
        .NUM_LANES(NL), .NUM_THREADS(NT), .NUM_WARPS(NW),
        .XLEN(XL), .PC_BITS(PCB), .RSP_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_wid(in_wid), .in_op(in_op),
        .in_neg(in_neg), .in_tmask(in_tmask), .in_pid(in_pid), .in_sop(in_sop),
        .in_eop(in_eop), .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .ctl_valid(ctl_valid), .ctl_wid(ctl_wid), .ctl_op(ctl_op),
        .ctl_tmask(ctl_tmask), .ctl_else_tmask(ctl_else_tmask),
        .ctl_is_dvg(ctl_is_dvg), .ctl_next_pc(ctl_next_pc), .ctl_arg(ctl_arg),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wid(rsp_wid),
        .rsp_eop(rsp_eop), .err_seq(err_seq)
    );

    int nvec = 0;
    int nerr = 0;

    // Warp-level reference state
    bit            m_act  [NW];
    logic [NT-1:0] m_then [NW];
    logic [NT-1:0] m_else [NW];
    logic          m_err;

    // Record captured at the most recent ctl pulse
    logic [NT-1:0]  cap_tmask, cap_else;
    logic           cap_dvg;
    logic [PCB-1:0] cap_pc;
    logic [XL-1:0]  cap_arg;
    logic [1:0]     cap_wid;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NL*XL-1:0] lanes(input logic [XL-1:0] l0, l1, l2, l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic model_reset();
        for (int w = 0; w < NW; w++) begin
            m_act[w]  = 1'b0;
            m_then[w] = '0;
            m_else[w] = '0;
        end
        m_err = 1'b0;
    endtask

    task automatic set_pkt(input logic [1:0] w, input logic [2:0] op, input logic neg,
                           input logic [NL-1:0] tm, input logic pid, input logic sop,
                           input logic eop, input logic [PCB-1:0] pc,
                           input logic [NL*XL-1:0] rs1, input logic [NL*XL-1:0] rs2);
        in_wid = w; in_op = op; in_neg = neg; in_tmask = tm; in_pid = pid;
        in_sop = sop; in_eop = eop; in_pc = pc; in_rs1 = rs1; in_rs2 = rs2;
    endtask

    // One packet through the DUT, checked against the warp-level model.
    task automatic send(input logic [1:0] w, input logic [2:0] op, input logic neg,
                        input logic [NL-1:0] tm, input logic pid, input logic sop,
                        input logic eop, input logic [PCB-1:0] pc,
                        input logic [NL*XL-1:0] rs1, input logic [NL*XL-1:0] rs2);
        bit             restart;
        int             lane;
        logic [XL-1:0]  r1, r2;
        logic [NT-1:0]  e_tm, e_el;
        logic           e_dvg;
        logic [PCB-1:0] e_pc;
        logic [XL-1:0]  e_arg;

        set_pkt(w, op, neg, tm, pid, sop, eop, pc, rs1, rs2);
        in_valid = 1'b1;
        chk("in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;

        // Model: a packet out of sequence flags the error and starts over.
        restart = sop || !m_act[w];
        if (sop == m_act[w]) m_err = 1'b1;
        if (restart) begin
            m_then[w] = '0;
            m_else[w] = '0;
        end
        for (int i = 0; i < NL; i++) begin
            if (tm[i]) begin
                if (rs1[i*XL] ^ neg) m_then[w][pid*NL + i] = 1'b1;
                else                 m_else[w][pid*NL + i] = 1'b1;
            end
        end
        m_act[w] = !eop;

        lane = 0;
        for (int i = NL - 1; i >= 0; i--) begin
            if (tm[i]) begin
                lane = i;
                break;
            end
        end
        r1 = rs1[lane*XL +: XL];
        r2 = rs2[lane*XL +: XL];
        e_tm = '0; e_el = '0; e_dvg = 1'b0; e_pc = '0; e_arg = '0;
        case (op)
            3'd0: e_tm = r1[NT-1:0];
            3'd1: e_tm = (m_then[w] != 0) ? m_then[w] : r2[NT-1:0];
            3'd2: begin
                e_dvg = (m_then[w] != 0) && (m_else[w] != 0);
                if ($countones(m_then[w]) >= $countones(m_else[w])) begin
                    e_tm = m_then[w]; e_el = m_else[w];
                end else begin
                    e_tm = m_else[w]; e_el = m_then[w];
                end
                e_pc = pc + 30'd2;
            end
            3'd3: e_arg = r1;
            3'd4: e_arg = GBAR ? r1 : (r1 & 32'h7FFF_FFFF);
            3'd5: begin
                for (int k = 0; k < NW; k++) e_tm[k] = (k < r1) && (k != w);
                e_pc = r2[PCB:1];
            end
            default: ;
        endcase

        chk("ctl_valid", ctl_valid, eop);
        chk("err_seq", err_seq, m_err);
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_wid", rsp_wid, w);
        chk("rsp_eop", rsp_eop, eop);
        if (eop) begin
            chk("ctl_wid", ctl_wid, w);
            chk("ctl_op", ctl_op, op);
            chk("ctl_tmask", ctl_tmask, e_tm);
            chk("ctl_else_tmask", ctl_else_tmask, e_el);
            chk("ctl_is_dvg", ctl_is_dvg, e_dvg);
            chk("ctl_next_pc", ctl_next_pc, e_pc);
            chk("ctl_arg", ctl_arg, e_arg);
            cap_tmask = ctl_tmask; cap_else = ctl_else_tmask; cap_dvg = ctl_is_dvg;
            cap_pc = ctl_next_pc; cap_arg = ctl_arg; cap_wid = ctl_wid;
        end
        @(posedge clk); #1;
        chk("ctl_pulse_end", ctl_valid, 0);
        chk("rsp_drained", rsp_valid, 0);
    endtask

    initial begin
        logic [1:0]       rw;
        logic             rsop, reop;
        logic [2:0]       rop;
        logic [NL*XL-1:0] rrs1, rrs2;

        reset = 1'b0;
        in_valid = 1'b0;
        rsp_ready = 1'b1;
        set_pkt(2'd0, 3'd0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        model_reset();
        #1;
        chk("rst_ctl_valid", ctl_valid, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_err_seq", err_seq, 0);
        chk("rst_ctl_tmask", ctl_tmask, 0);
        chk("rst_ctl_arg", ctl_arg, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", in_ready, 1);

        // SPLIT accumulated across two packets: else set wins 5 to 3
        send(2'd1, 3'd2, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 30'h100, lanes(1, 1, 0, 0), '0);
        send(2'd1, 3'd2, 1'b0, 4'hF, 1'b1, 1'b0, 1'b1, 30'h100, lanes(1, 0, 0, 0), '0);
        chk("s1_tmask", cap_tmask, 8'hEC);
        chk("s1_else", cap_else, 8'h13);
        chk("s1_dvg", cap_dvg, 1);
        chk("s1_pc", cap_pc, 30'h102);

        // SPLIT next pc wraps modulo 2^PC_BITS
        send(2'd3, 3'd2, 1'b0, 4'h3, 1'b0, 1'b1, 1'b1, 30'h3FFF_FFFF, lanes(1, 1, 0, 0), '0);
        chk("split_pc_wrap", cap_pc, 30'h1);
        chk("split_nodvg", cap_dvg, 0);

        // PRED with nothing taken falls back to rs2 of last lane; neg inverts
        send(2'd0, 3'd1, 1'b0, 4'hF, 1'b0, 1'b1, 1'b1, '0, '0, lanes(0, 0, 0, 32'hFF));
        chk("s2_pred_fallback", cap_tmask, 8'hFF);
        send(2'd0, 3'd1, 1'b1, 4'hF, 1'b0, 1'b1, 1'b1, '0, '0, lanes(0, 0, 0, 32'hFF));
        chk("pred_neg", cap_tmask, 8'h0F);

        // Interleaved warps accumulate independently
        send(2'd0, 3'd2, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 30'h40, lanes(1, 0, 1, 0), '0);
        send(2'd2, 3'd2, 1'b0, 4'h3, 1'b0, 1'b1, 1'b0, 30'h80, '0, '0);
        send(2'd0, 3'd2, 1'b0, 4'hF, 1'b1, 1'b0, 1'b1, 30'h40, lanes(1, 1, 1, 1), '0);
        chk("s3_w0_wid", cap_wid, 0);
        chk("s3_w0_tmask", cap_tmask, 8'hF5);
        chk("s3_w0_else", cap_else, 8'h0A);
        send(2'd2, 3'd2, 1'b0, 4'h1, 1'b1, 1'b0, 1'b1, 30'h80, lanes(1, 0, 0, 0), '0);
        chk("s3_w2_wid", cap_wid, 2);
        chk("s3_w2_tmask", cap_tmask, 8'h03);
        chk("s3_w2_else", cap_else, 8'h10);

        // TMC with empty tmask takes lane 0
        send(2'd1, 3'd0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, '0, lanes(32'h5A, 32'h11, 32'h22, 32'h33), '0);
        chk("tmc_lane0", cap_tmask, 8'h5A);

        // BAR global flag
        send(2'd2, 3'd4, 1'b0, 4'h8, 1'b0, 1'b1, 1'b1, '0, lanes(7, 7, 7, 32'h8000_0003), '0);
        chk("s6_bar_arg", cap_arg, GBAR ? 32'h8000_0003 : 32'h0000_0003);

        // WSPAWN: warps below 3 except self
        send(2'd1, 3'd5, 1'b0, 4'hF, 1'b0, 1'b1, 1'b1, '0, lanes(9, 9, 9, 3), lanes(0, 0, 0, 32'h200));
        chk("wspawn_mask", cap_tmask, 8'h05);
        chk("wspawn_pc", cap_pc, 30'h100);

        // Response FIFO back-pressure, then simultaneous pop and push when full
        rsp_ready = 1'b0;
        set_pkt(2'd0, 3'd3, 1'b0, 4'h1, 1'b0, 1'b1, 1'b1, '0, '0, '0);
        in_valid = 1'b1;
        @(posedge clk); #1;
        chk("s4_ready_one", in_ready, 1);
        set_pkt(2'd1, 3'd3, 1'b0, 4'h1, 1'b0, 1'b1, 1'b1, '0, '0, '0);
        @(posedge clk); #1;
        chk("s4_full", in_ready, 0);
        chk("s4_head0", rsp_wid, 0);
        set_pkt(2'd2, 3'd3, 1'b0, 4'h1, 1'b0, 1'b1, 1'b1, '0, '0, '0);
        @(posedge clk); #1;
        chk("s4_stall", in_ready, 0);
        chk("s4_head_hold", rsp_wid, 0);
        rsp_ready = 1'b1;
        #1;
        chk("s4_ready_on_pop", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("s4_head1", rsp_wid, 1);
        rsp_ready = 1'b0;
        #1;
        chk("s4_still_full", in_ready, 0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("s4_head2", rsp_wid, 2);
        chk("s4_head2_eop", rsp_eop, 1);
        @(posedge clk); #1;
        chk("s4_empty", rsp_valid, 0);

        // Randomized legal packet stream across all warps and ops
        for (int n = 0; n < 300; n++) begin
            rw   = 2'($urandom_range(0, NW - 1));
            rsop = !m_act[rw];
            reop = rsop ? ($urandom_range(0, 2) == 0) : 1'($urandom_range(0, 1));
            rop  = 3'($urandom_range(0, 5));
            for (int i = 0; i < NL; i++) begin
                rrs1[i*XL +: XL] = (rop == 3'd5) ? XL'($urandom_range(0, 5)) : $urandom;
                rrs2[i*XL +: XL] = $urandom;
            end
            send(rw, rop, 1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)),
                 rsop, reop, 30'($urandom), rrs1, rrs2);
        end
        for (int w = 0; w < NW; w++) begin
            if (m_act[w]) send(2'(w), 3'd2, 1'b0, 4'hF, 1'b1, 1'b0, 1'b1, 30'h10, lanes(1, 0, 1, 0), '0);
        end

        // Sequencing error is sticky; reset mid-accumulation discards it all
        send(2'd0, 3'd0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        chk("s5_err_set", err_seq, 1);
        send(2'd0, 3'd0, 1'b0, 4'hF, 1'b1, 1'b0, 1'b0, '0, '0, '0);
        chk("s5_err_sticky", err_seq, 1);
        reset = 1'b0;
        #1;
        chk("s5_rst_err", err_seq, 0);
        chk("s5_rst_ctl", ctl_valid, 0);
        chk("s5_rst_rsp", rsp_valid, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        model_reset();
        @(posedge clk); #1;
        chk("s5_no_pulse", ctl_valid, 0);
        chk("s5_ready", in_ready, 1);
        send(2'd0, 3'd1, 1'b0, 4'hF, 1'b0, 1'b1, 1'b1, '0, '0, lanes(0, 0, 0, 32'h3C));
        chk("s5_fresh_pred", cap_tmask, 8'h3C);
        chk("s5_err_clear", err_seq, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
